btn_pulse_gen: RTL and testbench

BTN_PULSE_GEN -- requirements
Module: btn_pulse_gen

---
 rtl/btn_pulse_gen.sv | 123 ++++++++++++
 tb/tb_btn_pulse_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_pulse_gen.sv
// ---------------------------------------------------------------------------
// btn_pulse_gen
// Debounces seven push buttons. Each button is synchronized, filtered by its
// own four-state debounce FSM, and turned into a registered debounced level
// plus a single-cycle pulse on every accepted press (no auto-repeat).
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        asynchronous reset, active low (0 = reset)
//   BTN_raw    raw bouncing button levels, 1 = pressed
//   BTN_pulse  registered one-cycle pulse per accepted press
//   BTN_level  registered debounced level (1 while HELD or RELEASE_CHK)
// ---------------------------------------------------------------------------
module btn_pulse_gen #(
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] BTN_raw,
    output logic [6:0] BTN_pulse,
    output logic [6:0] BTN_level
);

    localparam int unsigned N_BTN = 7;

    localparam logic [1:0] ST_RELEASED    = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
    localparam logic [1:0] ST_HELD        = 2'd2;
    localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

    // Terminal count: the counter never goes past this value, so it cannot wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [N_BTN-1:0]            sync1_q, sync1_d;
    logic [N_BTN-1:0]            sync2_q, sync2_d;
    logic [N_BTN-1:0][1:0]       state_q, state_d;
    logic [N_BTN-1:0][CNT_W-1:0] cnt_q,   cnt_d;
    logic [N_BTN-1:0]            pulse_q, pulse_d;
    logic [N_BTN-1:0]            level_q, level_d;

    // Two-flop synchronizer; sync2_q is the only input seen by the FSMs.
    always_comb begin
        sync1_d = BTN_raw;
        sync2_d = sync1_q;
    end

    // Per-button debounce FSM, counter and registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = '0;
        level_d = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            case (state_q[i])
                ST_RELEASED: begin
                    cnt_d[i] = '0;
                    if (sync2_q[i]) begin
                        state_d[i] = ST_PRESS_CHK;
                    end
                end
                ST_PRESS_CHK: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_RELEASED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_HELD;
                        cnt_d[i]   = '0;
                        pulse_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_RELEASE_CHK;
                        cnt_d[i]   = '0;
                    end
                end
                ST_RELEASE_CHK: begin
                    // Bounce back high returns to HELD silently: no pulse here.
                    if (sync2_q[i]) begin
                        state_d[i] = ST_HELD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_RELEASED;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_RELEASED;
                    cnt_d[i]   = '0;
                end
            endcase
            level_d[i] = (state_d[i] == ST_HELD) || (state_d[i] == ST_RELEASE_CHK);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= {N_BTN{ST_RELEASED}};
            cnt_q   <= '0;
            pulse_q <= '0;
            level_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    assign BTN_pulse = pulse_q;
    assign BTN_level = level_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_btn_pulse_gen
// Self-checking bench for btn_pulse_gen with DB_CYCLES=4. A reference model
// treats each button as a debounced level that flips after DB_CYCLES+1
// consecutive synchronized samples disagreeing with it; a flip to 1 is a pulse.
// ---------------------------------------------------------------------------
module tb_btn_pulse_gen;

    localparam int unsigned DB  = 4;
    localparam int unsigned CW  = 8;

    logic       clk;
    logic       rst;
    logic [6:0] BTN_raw;
    logic [6:0] BTN_pulse;
    logic [6:0] BTN_level;

    int n_checks;
    int n_fail;

    // Reference model state.
    logic [6:0] m_h1, m_h2, m_lvl;
    int         m_run [7];
    logic [6:0] exp_pulse, exp_level;

    btn_pulse_gen #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .BTN_raw   (BTN_raw),
        .BTN_pulse (BTN_pulse),
        .BTN_level (BTN_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        m_h1 = '0;
        m_h2 = '0;
        m_lvl = '0;
        for (int i = 0; i < 7; i++) m_run[i] = 0;
        exp_pulse = '0;
        exp_level = '0;
    endtask

    // Drive one raw value, advance one clock, update the model, settle 1 time unit.
    task automatic tick(input logic [6:0] r);
        logic [6:0] s;
        BTN_raw = r;
        @(posedge clk);
        exp_pulse = '0;
        if (!rst) begin
            model_clear();
        end else begin
            s    = m_h2;
            m_h2 = m_h1;
            m_h1 = r;
            for (int i = 0; i < 7; i++) begin
                if (s[i] != m_lvl[i]) m_run[i] = m_run[i] + 1;
                else                  m_run[i] = 0;
                if (m_run[i] == int'(DB) + 1) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                    if (m_lvl[i]) exp_pulse[i] = 1'b1;
                end
            end
        end
        exp_level = m_lvl;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_clear();
        for (int j = 0; j < 3; j++) begin
            tick(7'h00);
            n_checks++;
            if (BTN_pulse !== 7'h00 || BTN_level !== 7'h00) begin
                n_fail++;
                $display("FAIL reset_hold: pulse=%b level=%b expected 0/0", BTN_pulse, BTN_level);
            end
        end
        rst = 1'b1;
        for (int j = 0; j < 20; j++) begin
            tick(7'h00);
            n_checks++;
            if (BTN_pulse !== 7'h00 || BTN_level !== 7'h00) begin
                n_fail++;
                $display("FAIL idle_after_reset cyc %0d: pulse=%b level=%b expected 0/0", j, BTN_pulse, BTN_level);
            end
        end
    endtask

    task automatic test_single_press();
        int npulse;
        npulse = 0;
        for (int j = 0; j < 50; j++) begin
            tick(7'h40);
            if (BTN_pulse[6]) npulse++;
            n_checks++;
            if (BTN_pulse !== ((j == 6) ? 7'h40 : 7'h00)) begin
                n_fail++;
                $display("FAIL single_press_pulse cyc %0d: got %b expected %b", j, BTN_pulse, (j == 6) ? 7'h40 : 7'h00);
            end
            n_checks++;
            if (BTN_level !== ((j >= 6) ? 7'h40 : 7'h00)) begin
                n_fail++;
                $display("FAIL single_press_level cyc %0d: got %b", j, BTN_level);
            end
        end
        for (int j = 0; j < 20; j++) begin
            tick(7'h00);
            if (BTN_pulse[6]) npulse++;
            n_checks++;
            if (BTN_level !== ((j < 6) ? 7'h40 : 7'h00) || BTN_pulse !== 7'h00) begin
                n_fail++;
                $display("FAIL single_release cyc %0d: level=%b pulse=%b", j, BTN_level, BTN_pulse);
            end
        end
        n_checks++;
        if (npulse != 1) begin
            n_fail++;
            $display("FAIL single_press_count: got %0d pulses expected 1", npulse);
        end
    endtask

    task automatic test_press_glitch();
        logic [6:0] pat [7];
        pat = '{7'h08, 7'h08, 7'h08, 7'h00, 7'h08, 7'h08, 7'h08};
        for (int j = 0; j < 20; j++) begin
            tick((j < 7) ? pat[j] : 7'h00);
            n_checks++;
            if (BTN_pulse !== 7'h00 || BTN_level !== 7'h00) begin
                n_fail++;
                $display("FAIL press_glitch cyc %0d: pulse=%b level=%b expected 0/0", j, BTN_pulse, BTN_level);
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int j = 0; j < 12; j++) begin
            tick(7'h21);
            n_checks++;
            if (BTN_pulse !== ((j == 6) ? 7'h21 : 7'h00)) begin
                n_fail++;
                $display("FAIL simultaneous cyc %0d: got %b expected %b", j, BTN_pulse, (j == 6) ? 7'h21 : 7'h00);
            end
        end
        for (int j = 0; j < 12; j++) begin
            tick(7'h00);
            n_checks++;
            if (BTN_pulse !== exp_pulse || BTN_level !== exp_level) begin
                n_fail++;
                $display("FAIL simultaneous_release cyc %0d: pulse=%b/%b level=%b/%b", j, BTN_pulse, exp_pulse, BTN_level, exp_level);
            end
        end
    endtask

    task automatic test_release_bounce();
        int npulse;
        logic [6:0] r;
        npulse = 0;
        for (int j = 0; j < 35; j++) begin
            // press 15 cycles, then 0,1,0 bounce, then stable low
            if (j < 15)       r = 7'h04;
            else if (j == 16) r = 7'h04;
            else              r = 7'h00;
            tick(r);
            if (BTN_pulse[2]) npulse++;
            n_checks++;
            if (BTN_pulse !== exp_pulse || BTN_level !== exp_level) begin
                n_fail++;
                $display("FAIL release_bounce cyc %0d: pulse=%b/%b level=%b/%b", j, BTN_pulse, exp_pulse, BTN_level, exp_level);
            end
            if (j >= 6 && j <= 19) begin
                n_checks++;
                if (BTN_level[2] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL release_bounce_level cyc %0d: got %b expected 1", j, BTN_level[2]);
                end
            end
        end
        n_checks++;
        if (npulse != 1 || BTN_level !== 7'h00) begin
            n_fail++;
            $display("FAIL release_bounce_count: pulses=%0d level=%b expected 1 and 0", npulse, BTN_level);
        end
    endtask

    task automatic test_reset_mid_held();
        for (int j = 0; j < 10; j++) tick(7'h02);
        n_checks++;
        if (BTN_level !== 7'h02) begin
            n_fail++;
            $display("FAIL pre_reset_level: got %b expected 0000010", BTN_level);
        end
        rst = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (BTN_pulse !== 7'h00 || BTN_level !== 7'h00) begin
            n_fail++;
            $display("FAIL async_reset: pulse=%b level=%b expected 0/0", BTN_pulse, BTN_level);
        end
        for (int j = 0; j < 2; j++) begin
            tick(7'h02);
            n_checks++;
            if (BTN_pulse !== 7'h00 || BTN_level !== 7'h00) begin
                n_fail++;
                $display("FAIL in_reset cyc %0d: pulse=%b level=%b", j, BTN_pulse, BTN_level);
            end
        end
        rst = 1'b1;
        for (int j = 0; j < 15; j++) begin
            tick(7'h02);
            n_checks++;
            if (BTN_pulse !== ((j == 6) ? 7'h02 : 7'h00) || BTN_level !== ((j >= 6) ? 7'h02 : 7'h00)) begin
                n_fail++;
                $display("FAIL reset_repress cyc %0d: pulse=%b level=%b", j, BTN_pulse, BTN_level);
            end
        end
        for (int j = 0; j < 10; j++) tick(7'h00);
    endtask

    task automatic test_random();
        logic [6:0] r;
        int         mism;
        int         np_dut, np_ref;
        r = '0;
        mism = 0;
        np_dut = 0;
        np_ref = 0;
        for (int j = 0; j < 1500; j++) begin
            for (int i = 0; i < 7; i++)
                if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
            tick(r);
            np_dut += $countones(BTN_pulse);
            np_ref += $countones(exp_pulse);
            n_checks++;
            if (BTN_pulse !== exp_pulse || BTN_level !== exp_level) begin
                n_fail++;
                mism++;
                if (mism <= 10)
                    $display("FAIL random cyc %0d: raw=%b pulse=%b/%b level=%b/%b", j, r, BTN_pulse, exp_pulse, BTN_level, exp_level);
            end
        end
        for (int j = 0; j < 12; j++) tick(7'h00);
        n_checks++;
        if (BTN_level !== 7'h00 || np_dut != np_ref) begin
            n_fail++;
            $display("FAIL random_final: level=%b pulses=%0d expected %0d", BTN_level, np_dut, np_ref);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        BTN_raw  = '0;
        model_clear();
        test_reset();
        test_single_press();
        test_press_glitch();
        test_simultaneous();
        test_release_bounce();
        test_reset_mid_held();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
